// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Main decoder for the single-issue MIPS datapath. Turns the
//               6-bit primary opcode into the datapath control word and
//               registers it, so the controls line up with the pipeline
//               register that follows decode (one clock of latency).
//
// Ports       : clk       in   1  system clock, rising edge
//               rst_n     in   1  asynchronous active-low reset
//               OPCode    in   6  instruction bits [31:26]
//               WriteReg  out  1  register-file write enable
//               MemToReg  out  1  write-back source: 1 = memory, 0 = ALU
//               Branch    out  1  beq in progress
//               ReadMem   out  1  data-memory read enable
//               WriteMem  out  1  data-memory write enable
//               DstReg    out  1  destination: 1 = rd, 0 = rt
//               ALUSrc    out  1  ALU operand B: 1 = sign-ext imm, 0 = rt
//               ALU_OP    out  2  00 add, 01 subtract, 10 funct, 11 unused
//
// Revision    : 1.0  initial release
// ============================================================================
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OPCode,
    output logic       WriteReg,
    output logic       MemToReg,
    output logic       Branch,
    output logic       ReadMem,
    output logic       WriteMem,
    output logic       DstReg,
    output logic       ALUSrc,
    output logic [1:0] ALU_OP
);

    // Opcode encodings fixed by the MIPS ISA.
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    // ALU operation classes.
    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT = 2'b10;

    // Combinational decode.
    logic       w_write_reg;
    logic       w_mem_to_reg;
    logic       w_branch;
    logic       w_read_mem;
    logic       w_write_mem;
    logic       w_dst_reg;
    logic       w_alu_src;
    logic [1:0] w_alu_op;

    // Registered control word.
    logic       r_write_reg;
    logic       r_mem_to_reg;
    logic       r_branch;
    logic       r_read_mem;
    logic       r_write_mem;
    logic       r_dst_reg;
    logic       r_alu_src;
    logic [1:0] r_alu_op;

    // Everything defaults to the NOP word. Unlisted opcodes, and any opcode
    // carrying X/Z (which matches no case item), fall through to it. Fields
    // that are don't-care for sw/beq are left at 0 rather than X.
    always_comb begin
        w_write_reg  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_branch     = 1'b0;
        w_read_mem   = 1'b0;
        w_write_mem  = 1'b0;
        w_dst_reg    = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = c_ALU_ADD;

        case (OPCode)
            c_OP_RTYPE: begin
                w_write_reg = 1'b1;
                w_dst_reg   = 1'b1;
                w_alu_op    = c_ALU_FUNCT;
            end
            c_OP_LW: begin
                w_write_reg  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_read_mem   = 1'b1;
                w_alu_src    = 1'b1;
            end
            c_OP_SW: begin
                w_write_mem = 1'b1;
                w_alu_src   = 1'b1;
            end
            c_OP_BEQ: begin
                w_branch = 1'b1;
                w_alu_op = c_ALU_SUB;
            end
            c_OP_ADDI: begin
                w_write_reg = 1'b1;
                w_alu_src   = 1'b1;
            end
            default: begin
                w_alu_op = c_ALU_ADD;
            end
        endcase
    end

    // Output registers: cleared immediately by reset, otherwise a fresh
    // decode is captured on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_reg  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
            r_read_mem   <= 1'b0;
            r_write_mem  <= 1'b0;
            r_dst_reg    <= 1'b0;
            r_alu_src    <= 1'b0;
            r_alu_op     <= 2'b00;
        end else begin
            r_write_reg  <= w_write_reg;
            r_mem_to_reg <= w_mem_to_reg;
            r_branch     <= w_branch;
            r_read_mem   <= w_read_mem;
            r_write_mem  <= w_write_mem;
            r_dst_reg    <= w_dst_reg;
            r_alu_src    <= w_alu_src;
            r_alu_op     <= w_alu_op;
        end
    end

    assign WriteReg = r_write_reg;
    assign MemToReg = r_mem_to_reg;
    assign Branch   = r_branch;
    assign ReadMem  = r_read_mem;
    assign WriteMem = r_write_mem;
    assign DstReg   = r_dst_reg;
    assign ALUSrc   = r_alu_src;
    assign ALU_OP   = r_alu_op;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit. Expected control words
//               come from a rule-based reference model of the decode table.
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] OPCode;
    logic       WriteReg, MemToReg, Branch, ReadMem, WriteMem, DstReg, ALUSrc;
    logic [1:0] ALU_OP;

    int n_cmp;
    int n_fail;

    control_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .OPCode   (OPCode),
        .WriteReg (WriteReg),
        .MemToReg (MemToReg),
        .Branch   (Branch),
        .ReadMem  (ReadMem),
        .WriteMem (WriteMem),
        .DstReg   (DstReg),
        .ALUSrc   (ALUSrc),
        .ALU_OP   (ALU_OP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed word, bit order WriteReg MemToReg Branch ReadMem WriteMem DstReg ALUSrc ALU_OP[1:0]
    function automatic logic [8:0] obs();
        return {WriteReg, MemToReg, Branch, ReadMem, WriteMem, DstReg, ALUSrc, ALU_OP};
    endfunction

    // Reference model: derived from instruction class semantics.
    function automatic logic [8:0] model(input logic [5:0] op);
        bit is_r, is_lw, is_sw, is_beq, is_addi;
        bit wr, m2r, br, rd, wm, dst, src;
        logic [1:0] aop;
        is_r    = (op == 6'd0);
        is_lw   = (op == 6'd35);
        is_sw   = (op == 6'd43);
        is_beq  = (op == 6'd4);
        is_addi = (op == 6'd8);
        wr  = is_r | is_lw | is_addi;
        m2r = is_lw;
        br  = is_beq;
        rd  = is_lw;
        wm  = is_sw;
        dst = is_r;
        src = is_lw | is_sw | is_addi;
        aop = is_r ? 2'd2 : (is_beq ? 2'd1 : 2'd0);
        return {wr, m2r, br, rd, wm, dst, src, aop};
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        OPCode = 6'b000000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs() !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", obs(), 9'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 9'b1_0_0_0_0_1_0_10) begin
            n_fail++;
            $display("FAIL reset_release_rtype: got %b expected %b", obs(), 9'b100001010);
        end
    endtask

    task automatic test_table_sweep();
        logic [5:0] ops [4];
        logic [8:0] exp_w;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000100; ops[3] = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            OPCode = ops[i];
            exp_w  = model(ops[i]);
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== exp_w) begin
                n_fail++;
                $display("FAIL sweep_op%b: got %b expected %b", ops[i], obs(), exp_w);
            end
            #3;   // late in the cycle, before the next edge
            n_cmp++;
            if (obs() !== exp_w) begin
                n_fail++;
                $display("FAIL sweep_stable_op%b: got %b expected %b", ops[i], obs(), exp_w);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [3];
        ops[0] = 6'b000010; ops[1] = 6'b111111; ops[2] = 6'b001101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            OPCode = ops[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== 9'd0) begin
                n_fail++;
                $display("FAIL illegal_op%b: got %b expected %b", ops[i], obs(), 9'd0);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        OPCode = 6'b100011;
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 9'b1_1_0_1_0_0_1_00) begin
            n_fail++;
            $display("FAIL async_pre_lw: got %b expected %b", obs(), 9'b110100100);
        end
        #1;
        rst_n = 1'b0;       // between edges
        #1;
        n_cmp++;
        if (obs() !== 9'd0) begin
            n_fail++;
            $display("FAIL async_clear: got %b expected %b", obs(), 9'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 9'd0) begin
            n_fail++;
            $display("FAIL async_release_before_edge: got %b expected %b", obs(), 9'd0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 9'b110100100) begin
            n_fail++;
            $display("FAIL async_restore_lw: got %b expected %b", obs(), 9'b110100100);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [2];
        logic exp_wm [2];
        logic exp_rm [2];
        ops[0] = 6'b101011; exp_wm[0] = 1'b1; exp_rm[0] = 1'b0;
        ops[1] = 6'b100011; exp_wm[1] = 1'b0; exp_rm[1] = 1'b1;
        @(negedge clk);
        OPCode = ops[0];
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) OPCode = ops[1];
            n_cmp++;
            if (WriteMem !== exp_wm[i] || ReadMem !== exp_rm[i]) begin
                n_fail++;
                $display("FAIL b2b_step%0d: got wm=%b rm=%b expected wm=%b rm=%b",
                         i, WriteMem, ReadMem, exp_wm[i], exp_rm[i]);
            end
            n_cmp++;
            if (WriteMem === 1'b1 && ReadMem === 1'b1) begin
                n_fail++;
                $display("FAIL b2b_excl%0d: got both enables 1 expected at most one", i);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [5:0] ops [64];
        logic [5:0] tmp;
        logic [8:0] exp_w;
        int j;
        int n;
        for (int i = 0; i < 64; i++) ops[i] = 6'(i);
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = ops[i]; ops[i] = ops[j]; ops[j] = tmp;
        end
        n = 64 + 200;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            OPCode = (k < 64) ? ops[k] : 6'($urandom_range(63, 0));
            exp_w  = model(OPCode);
            @(posedge clk);
            #1;
            n_cmp++;
            if (obs() !== exp_w) begin
                n_fail++;
                $display("FAIL exh_op%b: got %b expected %b", OPCode, obs(), exp_w);
            end
            n_cmp++;
            if ((ReadMem && WriteMem) || (WriteMem && WriteReg) ||
                (Branch && (WriteReg || ReadMem || WriteMem)) || (ALU_OP === 2'b11)) begin
                n_fail++;
                $display("FAIL exh_invariant_op%b: got %b expected invariants to hold", OPCode, obs());
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        OPCode = 6'd0;
        test_reset();
        test_table_sweep();
        test_illegal();
        test_async_reset();
        test_back_to_back();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder of the single-issue MIPS datapath.
- Translates the 6-bit instruction opcode into the datapath control signals: register write, memory read/write, branch, destination-register select, ALU source select and the 2-bit ALU operation class.
- Outputs are registered, giving one clock of latency, so they line up with the pipeline register after decode.
- Feeds the register file, data memory, the PC/branch logic and the ALU control block.

Parameters:
- None. Opcode encodings are fixed by the MIPS ISA.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- OPCode  input  6  instruction bits [31:26]
- WriteReg  output  1  register-file write enable
- MemToReg  output  1  1 = write-back data from memory, 0 = from ALU
- Branch  output  1  conditional branch (beq) in progress
- ReadMem  output  1  data-memory read enable
- WriteMem  output  1  data-memory write enable
- DstReg  output  1  1 = destination is rd, 0 = rt
- ALUSrc  output  1  1 = ALU operand B is the sign-extended immediate, 0 = rt
- ALU_OP  output  2  00 add, 01 subtract (compare), 10 use funct field, 11 reserved (never driven)

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low.
  - While rst_n = 0, all outputs are 0 immediately, independent of clk.
  - Asserting rst_n mid-operation clears the outputs at once.
  - The first rising edge with rst_n = 1 loads the decode of the OPCode present at that edge.
- Latency: combinational decode of OPCode, captured into output registers on every rising clk edge.
  - Outputs reflect the OPCode sampled at the most recent edge.
  - Outputs are stable for the full following cycle.
  - No enable and no handshake: a new decode is taken every cycle.
- Decode table, bit order WriteReg MemToReg Branch ReadMem WriteMem DstReg ALUSrc ALU_OP:
  - 000000 R-type: 1 0 0 0 0 1 0 10
  - 100011 lw: 1 1 0 1 0 0 1 00
  - 101011 sw: 0 0 0 0 1 0 1 00
  - 000100 beq: 0 0 1 0 0 0 0 01
  - 001000 addi: 1 0 0 0 0 0 1 00
  - Any other opcode: all outputs 0, ALU_OP 00. This is a NOP with no architectural side effects.
- Don't-care fields (MemToReg/DstReg on sw and beq) are driven to 0, never X.
- Invariants:
  - ReadMem and WriteMem are never both 1.
  - WriteMem = 1 implies WriteReg = 0.
  - Branch = 1 implies WriteReg = 0 and both memory enables are 0.
- X/Z on OPCode must not propagate; such inputs decode as the default NOP.
- No internal state other than the output registers. No FSM.

Test Plan:
- Reset: rst_n = 0 with OPCode = 000000 and clk running -> all outputs 0. Release rst_n, one edge later -> R-type vector: WriteReg = 1, DstReg = 1, ALU_OP = 10, all other outputs 0.
- Table sweep: apply 100011, 101011, 000100, 001000 on successive edges -> each decode row matches the table exactly one cycle after its edge; no output changes between edges.
- Illegal opcodes: apply 000010, 111111 and 001101 -> all outputs 0, ALU_OP = 00.
- Asynchronous reset mid-cycle: while holding lw (WriteReg = 1, ReadMem = 1), pull rst_n low between edges -> outputs drop to 0 within the same cycle. After release, the next edge restores the lw vector.
- Back-to-back switching: sw immediately followed by lw -> WriteMem goes 1 then 0, ReadMem goes 0 then 1, and the two are never simultaneously 1 on any cycle.
- Exhaustive: all 64 opcodes, with a combinational golden model checked one cycle later -> zero mismatches and all invariants hold on every cycle.
